// File: rtl/rr_switch.sv
`default_nettype none
// ============================================================================
//  Module   : rr_switch
//  Purpose  : M_IN x N_OUT crossbar between the VC input slots and the link
//             output ports of a router node. Each output has its own
//             round-robin arbiter and a single registered output stage.
//             A transfer from slot i happens when in_valid[i] & in_avail[i].
//             The flit appears on the routed output one cycle later.
//  Options  : RR_SWITCH_PKT_LOCK_EN - when defined, an output that takes a
//             non-tail flit stays locked to that slot until its tail flit
//             passes (wormhole switching). When not defined, arbitration is
//             per flit.
//  Ports    : clk        clock, rising edge
//             rst        asynchronous reset, active low
//             in         slot flits, slot i at [i*FLIT_SIZE +: FLIT_SIZE]
//             route_in   slot routes, slot i at [i*ROUTE_LEN +: ROUTE_LEN]
//                        (value r in 1..N_OUT selects output r-1)
//             in_valid   slot holds a flit
//             in_tail    slot flit is the last flit of its packet
//             in_avail   combinational grant back to each slot
//             out        registered output flits
//             out_tail   registered tail flags
//             out_valid  output register occupied
//             out_avail  downstream accepts output this cycle
//  Revision : 1.0  initial parametrised release
// ============================================================================
module rr_switch #(
    parameter int M_IN      = 24,
    parameter int N_OUT     = 6,
    parameter int FLIT_SIZE = 32,
    parameter int ROUTE_LEN = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [M_IN*FLIT_SIZE-1:0]   in,
    input  logic [M_IN*ROUTE_LEN-1:0]   route_in,
    input  logic [M_IN-1:0]             in_valid,
    input  logic [M_IN-1:0]             in_tail,
    output logic [M_IN-1:0]             in_avail,
    output logic [N_OUT*FLIT_SIZE-1:0]  out,
    output logic [N_OUT-1:0]            out_tail,
    output logic [N_OUT-1:0]            out_valid,
    input  logic [N_OUT-1:0]            out_avail
);

    localparam int PTR_W = (M_IN > 1) ? $clog2(M_IN) : 1;

    // Slot views of the flat input buses
    logic [M_IN-1:0][FLIT_SIZE-1:0]   w_in_flit;
    logic [M_IN-1:0][ROUTE_LEN-1:0]   w_in_route;

    logic [N_OUT-1:0][M_IN-1:0]       w_req;
    logic [N_OUT-1:0][M_IN-1:0]       w_gnt;
    logic [N_OUT-1:0]                 w_can_load;
    logic [N_OUT-1:0]                 w_gnt_any;
    logic [N_OUT-1:0][PTR_W-1:0]      w_gnt_idx;
    logic [N_OUT-1:0][FLIT_SIZE-1:0]  w_gnt_flit;
    logic [N_OUT-1:0]                 w_gnt_tail;
    logic [N_OUT-1:0][PTR_W-1:0]      w_ptr_next;

    logic [N_OUT-1:0][PTR_W-1:0]      r_ptr;
    logic [N_OUT-1:0][FLIT_SIZE-1:0]  r_out;
    logic [N_OUT-1:0]                 r_out_tail;
    logic [N_OUT-1:0]                 r_out_valid;
`ifdef RR_SWITCH_PKT_LOCK_EN
    logic [N_OUT-1:0]                 r_locked;
    logic [N_OUT-1:0][PTR_W-1:0]      r_owner;
`endif

    assign w_in_flit  = in;
    assign w_in_route = route_in;

    // A route outside 1..N_OUT matches no output, so such a slot never
    // requests and never sees in_avail.
    always_comb begin
        w_req = '0;
        for (int o = 0; o < N_OUT; o++) begin
            for (int i = 0; i < M_IN; i++) begin
                w_req[o][i] = in_valid[i] && (w_in_route[i] == ROUTE_LEN'(o + 1));
            end
        end
    end

    // Per-output arbitration. A full register that drains this cycle may
    // reload in the same cycle, hence can_load includes out_avail.
    always_comb begin
        int w_scan_idx;
        w_scan_idx = 0;
        w_gnt      = '0;
        w_gnt_any  = '0;
        w_gnt_idx  = '0;
        w_can_load = '0;
        for (int o = 0; o < N_OUT; o++) begin
            w_can_load[o] = !r_out_valid[o] || out_avail[o];
`ifdef RR_SWITCH_PKT_LOCK_EN
            if (w_can_load[o] && r_locked[o]) begin
                // Mid-packet: only the owning slot may continue.
                if (w_req[o][r_owner[o]]) begin
                    w_gnt_any[o]             = 1'b1;
                    w_gnt_idx[o]             = r_owner[o];
                    w_gnt[o][r_owner[o]]     = 1'b1;
                end
            end else
`endif
            if (w_can_load[o]) begin
                // First requester at or after the pointer, wrapping.
                for (int k = 0; k < M_IN; k++) begin
                    w_scan_idx = (int'(r_ptr[o]) + k) % M_IN;
                    if (!w_gnt_any[o] && w_req[o][w_scan_idx]) begin
                        w_gnt_any[o]         = 1'b1;
                        w_gnt_idx[o]         = PTR_W'(w_scan_idx);
                        w_gnt[o][w_scan_idx] = 1'b1;
                    end
                end
            end
        end
    end

    // Granted data and the pointer value just past the winner.
    always_comb begin
        w_gnt_flit = '0;
        w_gnt_tail = '0;
        w_ptr_next = '0;
        for (int o = 0; o < N_OUT; o++) begin
            w_gnt_flit[o] = w_in_flit[w_gnt_idx[o]];
            w_gnt_tail[o] = in_tail[w_gnt_idx[o]];
            w_ptr_next[o] = PTR_W'((int'(w_gnt_idx[o]) + 1) % M_IN);
        end
    end

    // A slot only requests its routed output, so at most one bit per slot.
    always_comb begin
        in_avail = '0;
        for (int o = 0; o < N_OUT; o++) begin
            in_avail = in_avail | w_gnt[o];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out       <= '0;
            r_out_tail  <= '0;
            r_out_valid <= '0;
            r_ptr       <= '0;
`ifdef RR_SWITCH_PKT_LOCK_EN
            r_locked    <= '0;
            r_owner     <= '0;
`endif
        end else begin
            for (int o = 0; o < N_OUT; o++) begin
                if (w_can_load[o]) begin
                    if (w_gnt_any[o]) begin
                        r_out[o]       <= w_gnt_flit[o];
                        r_out_tail[o]  <= w_gnt_tail[o];
                        r_out_valid[o] <= 1'b1;
`ifdef RR_SWITCH_PKT_LOCK_EN
                        // The pointer only advances at packet end, so a
                        // single-flit packet never locks.
                        if (w_gnt_tail[o]) begin
                            r_locked[o] <= 1'b0;
                            r_ptr[o]    <= w_ptr_next[o];
                        end else begin
                            r_locked[o] <= 1'b1;
                            r_owner[o]  <= w_gnt_idx[o];
                        end
`else
                        r_ptr[o]       <= w_ptr_next[o];
`endif
                    end else begin
                        r_out_valid[o] <= 1'b0;
                    end
                end
            end
        end
    end

    assign out       = r_out;
    assign out_tail  = r_out_tail;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire
